// File: rtl/alu_share_arb_if.sv
// +--------------------------------------------------------------------+
// | Module   : alu_share_arb_if                                        |
// | Brief    : Request/response/alu bundle for the shared-alu arbiter. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
`default_nettype none

`ifndef ALU_OP_W
`define ALU_OP_W 4
`endif

interface alu_share_arb_if #(
    parameter int DATA_W = 32
);
    localparam int ALU_OP_W = `ALU_OP_W;

    // Port 0 request / response
    logic                req0_valid;
    logic                req0_ready;
    logic [ALU_OP_W-1:0] req0_op;
    logic [DATA_W-1:0]   req0_a;
    logic [DATA_W-1:0]   req0_b;
    logic                rsp0_valid;
    logic                rsp0_ready;
    logic [DATA_W-1:0]   rsp0_eval;
    logic                rsp0_zero;

    // Port 1 request / response
    logic                req1_valid;
    logic                req1_ready;
    logic [ALU_OP_W-1:0] req1_op;
    logic [DATA_W-1:0]   req1_a;
    logic [DATA_W-1:0]   req1_b;
    logic                rsp1_valid;
    logic                rsp1_ready;
    logic [DATA_W-1:0]   rsp1_eval;
    logic                rsp1_zero;

    // Shared alu connection
    logic [DATA_W-1:0]   alu_opp_a;
    logic [DATA_W-1:0]   alu_opp_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   alu_eval;
    logic                alu_zero;

    // Requesters and result consumers
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_eval, rsp0_zero,
        input  req1_ready, rsp1_valid, rsp1_eval, rsp1_zero
    );

    // The arbiter itself
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_eval, rsp0_zero,
        output req1_ready, rsp1_valid, rsp1_eval, rsp1_zero,
        output alu_opp_a, alu_opp_b, alu_op,
        input  alu_eval, alu_zero
    );

    // The combinational alu being shared
    modport alu (
        input  alu_opp_a, alu_opp_b, alu_op,
        output alu_eval, alu_zero
    );
endinterface

`default_nettype wire

// File: rtl/alu_share_arb.sv
// +--------------------------------------------------------------------+
// | Module   : alu_share_arb                                           |
// | Brief    : Round-robin sharing of one combinational alu between    |
// |            two valid/ready requesters, one result slot per port.   |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
`default_nettype none

`ifndef ALU_OP_W
`define ALU_OP_W 4
`endif

module alu_share_arb #(
    parameter int DATA_W = 32
) (
    input  wire               clk,
    input  wire               rst,
    alu_share_arb_if.slave    bus
);
    localparam int ALU_OP_W = `ALU_OP_W;

    localparam logic [DATA_W-1:0]   c_zero_data = '0;
    localparam logic [ALU_OP_W-1:0] c_zero_op   = '0;

    // Index of the port granted most recently; the other port wins a tie.
    logic               r_last_grant;

    logic               r_rsp0_valid;
    logic [DATA_W-1:0]  r_rsp0_eval;
    logic               r_rsp0_zero;
    logic               r_rsp1_valid;
    logic [DATA_W-1:0]  r_rsp1_eval;
    logic               r_rsp1_zero;

    logic               w_free0;
    logic               w_free1;
    logic               w_elig0;
    logic               w_elig1;
    logic               w_grant0;
    logic               w_grant1;

    // A slot may be refilled in the same cycle its current result drains.
    assign w_free0 = !r_rsp0_valid || bus.rsp0_ready;
    assign w_free1 = !r_rsp1_valid || bus.rsp1_ready;
    assign w_elig0 = bus.req0_valid && w_free0;
    assign w_elig1 = bus.req1_valid && w_free1;

    // Round-robin grant: sole eligible port wins, a tie goes away from r_last_grant.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            w_grant0 = r_last_grant;
            w_grant1 = !r_last_grant;
        end else begin
            w_grant0 = w_elig0;
            w_grant1 = w_elig1;
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;

    // Steer the granted port's operands to the alu; idle drives zeros.
    always_comb begin
        bus.alu_opp_a = c_zero_data;
        bus.alu_opp_b = c_zero_data;
        bus.alu_op    = c_zero_op;
        if (w_grant0) begin
            bus.alu_opp_a = bus.req0_a;
            bus.alu_opp_b = bus.req0_b;
            bus.alu_op    = bus.req0_op;
        end else if (w_grant1) begin
            bus.alu_opp_a = bus.req1_a;
            bus.alu_opp_b = bus.req1_b;
            bus.alu_op    = bus.req1_op;
        end
    end

    // Capture alu results into the granted port's slot and track round-robin order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_rsp0_valid <= 1'b0;
            r_rsp0_eval  <= c_zero_data;
            r_rsp0_zero  <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_eval  <= c_zero_data;
            r_rsp1_zero  <= 1'b0;
        end else begin
            if (w_grant0) begin
                r_rsp0_valid <= 1'b1;
                r_rsp0_eval  <= bus.alu_eval;
                r_rsp0_zero  <= bus.alu_zero;
            end else if (bus.rsp0_ready) begin
                r_rsp0_valid <= 1'b0;
            end

            if (w_grant1) begin
                r_rsp1_valid <= 1'b1;
                r_rsp1_eval  <= bus.alu_eval;
                r_rsp1_zero  <= bus.alu_zero;
            end else if (bus.rsp1_ready) begin
                r_rsp1_valid <= 1'b0;
            end

            if (w_grant1) begin
                r_last_grant <= 1'b1;
            end else if (w_grant0) begin
                r_last_grant <= 1'b0;
            end
        end
    end

    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp0_eval  = r_rsp0_eval;
    assign bus.rsp0_zero  = r_rsp0_zero;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp1_eval  = r_rsp1_eval;
    assign bus.rsp1_zero  = r_rsp1_zero;

endmodule

`default_nettype wire
